// File: rtl/ascii_cmd_decoder_pkg.sv
// Shared definitions for the ASCII command decoder: character codes, FSM states and tag encodings.
package bip_uart_pkg;

  localparam logic [7:0] CR     = 8'd13;
  localparam logic [7:0] COLON  = 8'd58;
  localparam logic [7:0] CHAR_A = 8'd65;
  localparam logic [7:0] CHAR_C = 8'd67;
  localparam logic [7:0] CHAR_S = 8'd115;
  localparam logic [7:0] CHAR_0 = 8'd48;
  localparam logic [7:0] CHAR_9 = 8'd57;

  localparam logic TAG_ACC = 1'b0;
  localparam logic TAG_CNT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLON,
    ST_DIGITS,
    ST_SCMD,
    ST_DISCARD
  } dec_state_t;

endpackage

// File: rtl/ascii_cmd_decoder_if.sv
// Receiver-byte input and decoded-result outputs of the ASCII command decoder.
interface ascii_cmd_decoder_if #(
  parameter int DBIT = 8,
  parameter int VW   = 16
);
  logic            rx_done_tick;
  logic [DBIT-1:0] rx_data;
  logic [VW-1:0]   value;
  logic            tag;
  logic            value_tick;
  logic            start_tick;
  logic            err_tick;
  logic            busy;

  modport master (
    output rx_done_tick, rx_data,
    input  value, tag, value_tick, start_tick, err_tick, busy
  );

  modport slave (
    input  rx_done_tick, rx_data,
    output value, tag, value_tick, start_tick, err_tick, busy
  );
endinterface

// File: rtl/ascii_cmd_decoder_dec_acc.sv
// Decimal accumulator: acc <= acc*10 + digit with overflow detect.
// CMD_SAT_EN: clamp to all-ones on overflow instead of holding the old value.
module dec_acc #(
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_digit,
  input  logic [3:0]    digit,
  output logic [VW-1:0] acc,
  output logic          ovf
);

  logic [VW+3:0] wide;

  // acc*10 as (acc<<3)+(acc<<1); four guard bits hold the worst case.
  always_comb begin
    wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{VW{1'b0}}, digit};
    ovf  = |wide[VW+3:VW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load_digit) begin
`ifdef CMD_SAT_EN
      acc <= ovf ? '1 : wide[VW-1:0];
`else
      if (!ovf) acc <= wide[VW-1:0];
`endif
    end
  end

endmodule

// File: rtl/ascii_cmd_decoder.sv
// Line decoder for "A:<n>\r", "C:<n>\r" and "s\r" from a UART receiver.
// CMD_SAT_EN selects saturating operands instead of discarding on overflow.
module ascii_cmd_decoder
  import bip_uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int VW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  ascii_cmd_decoder_if.slave  bus
);

  dec_state_t      state, state_n;
  logic [2:0]      cnt, cnt_n;
  logic            tag_l, tag_l_n;
  logic [VW-1:0]   value_q, value_n;
  logic            tag_q, tag_n;
  logic            vt_q, vt_n, st_q, st_n, et_q, et_n;
  logic            clear, load_digit;
  logic [VW-1:0]   acc;
  logic            ovf;
  logic [DBIT-1:0] rx_byte;
  logic            is_digit;

  assign rx_byte  = bus.rx_data;
  assign is_digit = (rx_byte >= DBIT'(CHAR_0)) && (rx_byte <= DBIT'(CHAR_9));

  dec_acc #(.VW(VW)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_digit (load_digit),
    .digit      (rx_byte[3:0]),
    .acc        (acc),
    .ovf        (ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tag_l   <= TAG_ACC;
      value_q <= '0;
      tag_q   <= TAG_ACC;
      vt_q    <= 1'b0;
      st_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tag_l   <= tag_l_n;
      value_q <= value_n;
      tag_q   <= tag_n;
      vt_q    <= vt_n;
      st_q    <= st_n;
      et_q    <= et_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tag_l_n    = tag_l;
    value_n    = value_q;
    tag_n      = tag_q;
    vt_n       = 1'b0;
    st_n       = 1'b0;
    et_n       = 1'b0;
    clear      = 1'b0;
    load_digit = 1'b0;
    if (bus.rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == DBIT'(CHAR_A) || rx_byte == DBIT'(CHAR_C)) begin
            tag_l_n = (rx_byte == DBIT'(CHAR_C)) ? TAG_CNT : TAG_ACC;
            state_n = ST_COLON;
          end else if (rx_byte == DBIT'(CHAR_S)) begin
            state_n = ST_SCMD;
          end else if (rx_byte != DBIT'(CR)) begin
            state_n = ST_DISCARD;
          end
        end
        ST_COLON: begin
          if (rx_byte == DBIT'(COLON)) begin
            clear   = 1'b1;
            cnt_n   = '0;
            state_n = ST_DIGITS;
          end else if (rx_byte == DBIT'(CR)) begin
            et_n    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DISCARD;
          end
        end
        ST_DIGITS: begin
          if (is_digit) begin
            load_digit = 1'b1;
            cnt_n      = (cnt == 3'd7) ? cnt : cnt + 3'd1;
`ifndef CMD_SAT_EN
            if (ovf) state_n = ST_DISCARD;
`endif
          end else if (rx_byte == DBIT'(CR)) begin
            state_n = ST_IDLE;
            if (cnt != '0) begin
              value_n = acc;
              tag_n   = tag_l;
              vt_n    = 1'b1;
            end else begin
              et_n = 1'b1;
            end
          end else begin
            state_n = ST_DISCARD;
          end
        end
        ST_SCMD: begin
          if (rx_byte == DBIT'(CR)) begin
            st_n    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (rx_byte == DBIT'(CR)) begin
            et_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.value      = value_q;
  assign bus.tag        = tag_q;
  assign bus.value_tick = vt_q;
  assign bus.start_tick = st_q;
  assign bus.err_tick   = et_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ascii_cmd_decoder.sv
// Self-checking bench for ascii_cmd_decoder: line-level reference model plus directed and random lines.
module tb_ascii_cmd_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   checking = 1'b0;

  ascii_cmd_decoder_if #(.DBIT(8), .VW(16)) bus ();

  ascii_cmd_decoder #(.DBIT(8), .VW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: buffers each line and judges it as a whole when CR arrives.
  byte unsigned line_q[$];
  int unsigned  m_value;
  bit           m_tag, m_vt, m_st, m_et;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q.delete();
      m_value = 0; m_tag = 0; m_vt = 0; m_st = 0; m_et = 0;
    end else begin
      m_vt = 0; m_st = 0; m_et = 0;
      if (bus.rx_done_tick) begin
        if (bus.rx_data == 8'd13) begin
          if (line_q.size() != 0) judge_line();
          line_q.delete();
        end else begin
          line_q.push_back(bus.rx_data);
        end
      end
    end
  end

  task automatic judge_line();
    int    n;
    longint num;
    bit    ok;
    n = line_q.size();
    if (n == 1 && line_q[0] == "s") begin
      m_st = 1;
    end else if (n >= 3 && (line_q[0] == "A" || line_q[0] == "C") && line_q[1] == ":") begin
      ok = 1; num = 0;
      for (int i = 2; i < n; i++) begin
        if (line_q[i] < "0" || line_q[i] > "9") ok = 0;
        else begin
          num = num * 10 + (line_q[i] - 8'd48);
          if (num > 1000000) num = 1000000;
        end
      end
      if (ok && num > 65535) begin
`ifdef CMD_SAT_EN
        num = 65535;
`else
        ok = 0;
`endif
      end
      if (ok) begin
        m_value = int'(num); m_tag = (line_q[0] == "C"); m_vt = 1;
      end else begin
        m_et = 1;
      end
    end else begin
      m_et = 1;
    end
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("value", bus.value, m_value);
      check("tag", bus.tag, m_tag);
      check("value_tick", bus.value_tick, m_vt);
      check("start_tick", bus.start_tick, m_st);
      check("err_tick", bus.err_tick, m_et);
      check("busy", bus.busy, line_q.size() != 0);
      check("one_strobe", (32'(bus.value_tick) + 32'(bus.start_tick) + 32'(bus.err_tick)) <= 1, 1);
    end
  end

  // Drive a byte for one cycle, then hold random junk on rx_data for gap idle cycles.
  task automatic send_byte(input byte unsigned b, input int gap);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(posedge clk); #1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // The CR goes out last with no trailing gap, so strobes are visible on return.
  task automatic send_line(input string s, input int gap, input bit with_cr);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    if (with_cr) send_byte(8'd13, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic string rand_line();
    string s, z;
    int    k;
    byte unsigned junk[12];
    junk = '{"A", "C", "s", ":", "0", "5", "9", "x", "z", "1", ":", "A"};
    k = $urandom_range(0, 5);
    z = "";
    repeat ($urandom_range(0, 2)) z = {z, "0"};
    case (k)
      0: s = $sformatf("A:%s%0d", z, $urandom_range(0, 70000));
      1: s = $sformatf("C:%s%0d", z, $urandom_range(0, 70000));
      2: s = "s";
      3: begin
        s = "";
        repeat ($urandom_range(0, 4)) s = $sformatf("%s%c", s, junk[$urandom_range(0, 11)]);
      end
      4: s = "";
      default: s = $sformatf("A:%0d%0d", $urandom_range(100, 999), $urandom_range(100, 999));
    endcase
    return s;
  endfunction

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    #12;
    check("reset_value", bus.value, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_strobes", {bus.value_tick, bus.start_tick, bus.err_tick}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checking = 1'b1;

    send_line("A:123", 1, 1);
    check("a123_value", bus.value, 123);
    check("a123_tag", bus.tag, 0);
    check("a123_tick", bus.value_tick, 1);
    idle(2);

    send_line("C:00042", 0, 1);
    check("c42_value", bus.value, 42);
    check("c42_tag", bus.tag, 1);
    idle(1);
    send_line("s", 2, 1);
    check("s_start", bus.start_tick, 1);
    idle(2);

    send_line("A:65536", 1, 1);
`ifdef CMD_SAT_EN
    check("ovf_value", bus.value, 65535);
    check("ovf_tick", bus.value_tick, 1);
`else
    check("ovf_err", bus.err_tick, 1);
    check("ovf_value", bus.value, 42);
`endif
    idle(2);

    send_line("Ax5", 0, 1);  check("err_Ax5", bus.err_tick, 1);  check("busy_Ax5", bus.busy, 0);
    send_line("A:", 1, 1);   check("err_A", bus.err_tick, 1);    check("busy_A", bus.busy, 0);
    send_line("s1", 0, 1);   check("err_s1", bus.err_tick, 1);   check("busy_s1", bus.busy, 0);
    send_line("C:1z", 3, 1); check("err_C1z", bus.err_tick, 1); check("busy_C1z", bus.busy, 0);
    idle(2);

    send_line("A:12", 1, 0);
    #3 reset = 1'b1;
    #1;
    check("async_rst_value", bus.value, 0);
    check("async_rst_busy", bus.busy, 0);
    idle(2);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send_line("5", 0, 1);
    check("post_rst_err", bus.err_tick, 1);
    idle(1);
    send_line("C:7", 1, 1);
    check("c7_value", bus.value, 7);
    check("c7_tag", bus.tag, 1);
    idle(1);

    send_line("A:9", 0, 1);
    check("a9_gap0", bus.value, 9);
    send_line("C:3", 0, 1);
    send_line("A:9", 20, 1);
    check("a9_gap20", bus.value, 9);
    check("a9_gap20_tag", bus.tag, 0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      send_line(rand_line(), $urandom_range(0, 3), 1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_cmd_decoder.md
ASCII_CMD_DECODER -- requirements
Module: ascii_cmd_decoder

Interface
REQ-001 Parameter DBIT, default 8: UART data width in bits; only 8 is supported.
REQ-002 Parameter VW, default 16: width of the decoded value.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_done_tick  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-006 rx_data  input  DBIT  received ASCII byte from the UART receiver.
REQ-007 value  output  VW  last successfully decoded operand, registered.
REQ-008 tag  output  1  target of value: 0 = 'A' (accumulator), 1 = 'C' (counter).
REQ-009 value_tick  output  1  one-cycle strobe: value and tag updated.
REQ-010 start_tick  output  1  one-cycle strobe: start command "s\r" received.
REQ-011 err_tick  output  1  one-cycle strobe: malformed line discarded.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Accepted line formats are "A:<digits>\r", "C:<digits>\r" and "s\r"; CR is 13, ':' is 58, 's' is 115, 'A' is 65, 'C' is 67 and digits are 48..57.
REQ-014 rx_data is sampled only in cycles with rx_done_tick=1; all other cycles leave the state unchanged.
REQ-015 The FSM states are IDLE, COLON, DIGITS, SCMD and DISCARD.
REQ-016 IDLE transitions:
  - 'A' or 'C': latch the tag bit, go to COLON.
  - 's': go to SCMD.
  - CR: stay in IDLE, no strobe.
  - any other byte: go to DISCARD.
REQ-017 COLON transitions:
  - ':': clear the accumulator and digit count, go to DIGITS.
  - any other byte: go to DISCARD.
REQ-018 DIGITS handles bytes as follows:
  - digit d: acc <= acc*10 + d, computed at VW+4 bits, digit count incremented (saturating at 7).
  - CR with count > 0: go to IDLE.
  - CR with count = 0: go to IDLE and pulse err_tick.
  - any other byte: go to DISCARD.
REQ-019 SCMD transitions:
  - CR: pulse start_tick, go to IDLE.
  - any other byte: go to DISCARD.
REQ-020 DISCARD ignores all bytes except CR; on CR it pulses err_tick and returns to IDLE.
REQ-021 On an accepted "A:/C:" line, value and tag load and value_tick pulses in the cycle after the CR's rx_done_tick, i.e. 1-cycle latency.
REQ-022 value and tag hold their contents until the next accepted line; failed lines leave them unchanged.
REQ-023 All strobes last exactly one cycle, and at most one strobe is high in any cycle.
REQ-024 Leading zeros are accepted; the number of digits is limited only by overflow (REQ-031).
REQ-025 A line that ends in the non-IDLE states COLON or SCMD by receiving CR is an error; err_tick pulses.

Reset
REQ-026 Reset takes effect immediately, not on a clock edge.
REQ-027 Reset forces:
  - FSM to IDLE.
  - value=0 and tag=0.
  - value_tick, start_tick and err_tick to 0.
  - busy=0.
  - accumulator and digit count to 0.
REQ-028 A reset in the middle of a line discards that partial line, and no strobe fires.
REQ-029 After reset, the first byte is interpreted as the start of a new line.

Configuration
REQ-030 The macro CMD_SAT_EN, when defined, enables saturating accumulation: any digit that would make acc exceed 2^VW-1 clamps acc to 2^VW-1, the FSM stays in DIGITS, and the line is accepted at CR.
REQ-031 When CMD_SAT_EN is undefined, a digit that would make acc exceed 2^VW-1 sends the FSM to DISCARD, so err_tick pulses at the next CR.

Structure
REQ-032 The shared package bip_uart_pkg holds:
  - the ASCII constants CR, COLON, CHAR_A, CHAR_C, CHAR_S, CHAR_0 and CHAR_9.
  - the state encoding.
  - the tag encodings TAG_ACC and TAG_CNT.
REQ-033 The multiply-by-10 accumulate and overflow detect live in the single sub-module dec_acc, with inputs clear, load_digit and digit[3:0], and outputs acc[VW-1:0] and ovf.
REQ-034 All outputs are driven from registers; there are no combinational paths from rx_data to outputs.

Verification
REQ-035 Send "A:123\r": value=123, tag=0 and value_tick pulses 1 cycle after the CR; no other strobe.
REQ-036 Send "C:00042\r" then "s\r": value=42, tag=1, then exactly one start_tick.
REQ-037 Send "A:65536\r":
  - CMD_SAT_EN undefined: err_tick pulses and value is unchanged.
  - CMD_SAT_EN defined: value=65535 with value_tick.
REQ-038 Send "Ax5\r", "A:\r", "s1\r" and "C:1z\r": each gives one err_tick and no value_tick; busy is 0 after each CR.
REQ-039 Send "A:12", assert reset, then send "5\r":
  - the '5' goes to DISCARD and the CR pulses err_tick.
  - "C:7\r" sent afterwards yields value=7, tag=1.
REQ-040 Send "A:9\r" with rx_done_tick idle gaps of 0 and 20 cycles between bytes: identical results, and held rx_data between ticks is ignored.
